sig_stream_tx: RTL and testbench

- Hardware transmitter for the compliance-signature and halt convention on the data-memory bus.
- Sits beside Dmem and snoops the memory-stage address, write data and the active-low write strobe.
- Stores to SIG_ADDR are buffered in a word FIFO, then emitted as lowercase ASCII hex, one word per line (8 hex chars + 0x0A), over a valid/ready byte stream.
- A store to HALT_ADDR requests halt; `done` rises once every buffered word has been fully transmitted.

---
 rtl/sig_stream_tx_if.sv | 9 +
 rtl/sig_stream_tx.sv | 113 +++++++++++
 tb/tb_sig_stream_tx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sig_stream_tx_if.sv
// rtl/sig_stream_tx_if.sv - ASCII byte stream between the signature transmitter and its sink.
interface sig_stream_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sig_stream_tx.sv
// rtl/sig_stream_tx.sv - Snoops data-memory stores, buffers signature words and streams them as hex lines.
module sig_stream_tx #(
  parameter logic [31:0] SIG_ADDR  = 32'h00000f00,
  parameter logic [31:0] HALT_ADDR = 32'hcafebeef,
  parameter int          DEPTH     = 16,
  localparam int         AW        = $clog2(DEPTH),
  localparam int         CW        = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   addr,
  input  logic [31:0]   data_wr,
  input  logic          wr,
  sig_stream_tx_if.master tx,
  output logic          done,
  output logic          overflow,
  output logic [CW-1:0] fifo_count
);

  typedef enum logic [1:0] {IDLE, SEND, NL} state_e;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [31:0]   word_q, word_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          halt_q, done_q, ovf_q;

  logic          store, push_req, push_ok, pop;
  logic [3:0]    nibble;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  assign store    = !wr;
  assign push_req = store && (addr == SIG_ADDR) && !halt_q;
  assign pop      = (state_q == IDLE) && (count_q != '0);
  // A full FIFO still takes the word when the serializer frees a slot this cycle.
  assign push_ok  = push_req && ((count_q != DEPTH_C) || pop);
  assign nibble   = word_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    case (state_q)
      IDLE: begin
        if (pop) begin
          word_d  = mem[rd_ptr_q];
          idx_d   = 3'd7;
          state_d = SEND;
        end
      end
      SEND: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = hex(nibble);
        if (tx.tx_ready) begin
          if (idx_q == 3'd0) state_d = NL;
          else               idx_d   = idx_q - 3'd1;
        end
      end
      NL: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = 8'h0a;
        if (tx.tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      halt_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      halt_q <= halt_q | (store && (addr == HALT_ADDR));
      done_q <= done_q | (halt_q && (count_q == '0) && (state_q == IDLE));
      ovf_q  <= ovf_q | (push_req && !push_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= data_wr;
  end

  assign done       = done_q;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_sig_stream_tx.sv
// tb/tb_sig_stream_tx.sv - Bench for sig_stream_tx against a queue-based byte-stream reference.
module tb_sig_stream_tx;
  localparam logic [31:0] SIG  = 32'h00000f00;
  localparam logic [31:0] HALT = 32'hcafebeef;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, data_wr;
  logic        wr;
  logic        done, overflow;
  logic [4:0]  fifo_count;

  sig_stream_tx_if tx_if ();

  sig_stream_tx #(.SIG_ADDR(SIG), .HALT_ADDR(HALT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_wr(data_wr), .wr(wr),
    .tx(tx_if), .done(done), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference: words waiting, plus the bytes of the line currently being sent.
  logic [31:0] mfifo[$];
  logic [7:0]  line[$];
  bit          m_halt, m_done, m_ovf;
  int          nvec = 0, nerr = 0, hs_cnt = 0;

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(8'h30 + n) : 8'(8'h61 + n - 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit hs, popm;
    int sz;
    bit dn;
    hs   = (line.size() > 0) && tx_if.tx_ready;
    popm = (line.size() == 0) && (mfifo.size() > 0);
    sz   = mfifo.size();
    if (!rst && tx_if.tx_valid && tx_if.tx_ready) hs_cnt++;
    if (rst) begin
      mfifo.delete(); line.delete();
      m_halt = 0; m_done = 0; m_ovf = 0;
    end else begin
      dn = m_done || (m_halt && sz == 0 && line.size() == 0);
      if (hs) void'(line.pop_front());
      if (popm) begin
        logic [31:0] w;
        w = mfifo.pop_front();
        for (int i = 7; i >= 0; i--) line.push_back(hexc(int'((w >> (4*i)) & 32'hf)));
        line.push_back(8'h0a);
      end
      if (!wr && addr == SIG && !m_halt) begin
        if (sz < DEPTH || popm) mfifo.push_back(data_wr);
        else m_ovf = 1;
      end
      if (!wr && addr == HALT) m_halt = 1;
      m_done = dn;
    end
    @(posedge clk);
    #1;
    chk("tx_valid", 32'(tx_if.tx_valid), 32'(line.size() > 0));
    chk("tx_data", 32'(tx_if.tx_data), 32'((line.size() > 0) ? line[0] : 8'h00));
    chk("fifo_count", 32'(fifo_count), 32'(mfifo.size()));
    chk("done", 32'(done), 32'(m_done));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; data_wr = d; wr = 1'b0;
    tick();
    wr = 1'b1; addr = 32'h0; data_wr = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run(input int n, input bit rnd_ready);
    for (int i = 0; i < n; i++) begin
      if (rnd_ready) tx_if.tx_ready = 1'($urandom);
      tick();
    end
  endtask

  initial begin
    int base;
    bit found;
    rst = 1'b1; wr = 1'b1; addr = 32'h0; data_wr = 32'h0; tx_if.tx_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_valid", 32'(tx_if.tx_valid), 32'h0);
    chk("reset_count", 32'(fifo_count), 32'h0);

    // Single word, first byte two cycles after the store.
    base = hs_cnt;
    store(SIG, 32'hdeadbeef);
    chk("lat_k1_valid", 32'(tx_if.tx_valid), 32'h0);
    tick();
    chk("lat_k2_valid", 32'(tx_if.tx_valid), 32'h1);
    chk("lat_k2_data", 32'(tx_if.tx_data), 32'h64);
    run(10, 0);
    chk("single_bytes", 32'(hs_cnt - base), 32'd9);
    chk("single_count", 32'(fifo_count), 32'h0);

    // Backpressure.
    base = hs_cnt;
    store(SIG, 32'h0000000a);
    run(60, 1);
    tx_if.tx_ready = 1'b1;
    run(12, 0);
    chk("bp_bytes", 32'(hs_cnt - base), 32'd9);

    // Overflow with the sink stalled.
    tx_if.tx_ready = 1'b0;
    base = hs_cnt;
    for (int i = 0; i < DEPTH + 2; i++) store(SIG, $urandom);
    run(3, 0);
    chk("ovf_count", 32'(fifo_count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'h1);
    tx_if.tx_ready = 1'b1;
    run(18 * 10, 0);
    chk("ovf_bytes", 32'(hs_cnt - base), 32'(17 * 9));

    // Full FIFO, store lands on the pop cycle.
    do_reset();
    tx_if.tx_ready = 1'b0;
    base = hs_cnt;
    for (int i = 0; i < DEPTH + 1; i++) store(SIG, $urandom);
    chk("full_count", 32'(fifo_count), 32'd16);
    tx_if.tx_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (line.size() == 0 && mfifo.size() > 0) begin
        store(SIG, 32'h12345678);
        found = 1;
      end else tick();
    end
    chk("full_pop_found", 32'(found), 32'h1);
    chk("full_pop_ovf", 32'(overflow), 32'h0);
    chk("full_pop_count", 32'(fifo_count), 32'd16);
    run(18 * 10, 0);
    chk("full_pop_bytes", 32'(hs_cnt - base), 32'(18 * 9));

    // Halt drain: the store after halt is never sent.
    do_reset();
    base = hs_cnt;
    for (int i = 0; i < 3; i++) store(SIG, $urandom);
    store(HALT, 32'h0);
    store(SIG, 32'hffffffff);
    run(40, 0);
    chk("halt_done", 32'(done), 32'h1);
    chk("halt_bytes", 32'(hs_cnt - base), 32'd27);

    // Halt with nothing buffered.
    do_reset();
    store(HALT, 32'h0);
    chk("halt_empty_k1", 32'(done), 32'h0);
    tick();
    chk("halt_empty_k2", 32'(done), 32'h1);

    // Reset in the middle of a word.
    do_reset();
    store(SIG, 32'h89abcdef);
    store(SIG, 32'h01234567);
    run(5, 0);
    base = hs_cnt;
    do_reset();
    chk("midrst_valid", 32'(tx_if.tx_valid), 32'h0);
    chk("midrst_count", 32'(fifo_count), 32'h0);
    run(15, 0);
    chk("midrst_nobytes", 32'(hs_cnt - base), 32'h0);

    // Random mix of stores and sink stalls.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      tx_if.tx_ready = ($urandom_range(0, 3) != 0);
      addr = (r < 30) ? SIG : ((r == 99) ? HALT : $urandom);
      wr = (r < 30 || r == 99 || r > 80) ? 1'b0 : 1'b1;
      data_wr = $urandom;
      tick();
    end
    wr = 1'b1;
    tx_if.tx_ready = 1'b1;
    run(200, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
